// File: rtl/exec_cluster_scheduler.sv
// Dispatches issued ops to the lowest free functional unit of the matching class and
// returns buffered unit results over a round-robin arbitrated multi-port result bus.
module exec_cluster_scheduler #(
    parameter int                  DATA_WIDTH     = 32,
    parameter int                  ROB_ADDR_WIDTH = 5,
    parameter int                  NUM_FU         = 4,
    parameter logic [2*NUM_FU-1:0] FU_CLASS_MAP   = {2'd2, 2'd1, 2'd0, 2'd0},
    parameter int                  NUM_CDB        = 2,
    parameter int                  RES_DEPTH      = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              issue_valid_i,
    input  logic [1:0]                        issue_class_i,
    input  logic [ROB_ADDR_WIDTH-1:0]         issue_rob_tag_i,
    output logic                              issue_ready_o,
    output logic [NUM_FU-1:0]                 fu_start_o,
    input  logic [NUM_FU-1:0]                 fu_busy_i,
    input  logic [NUM_FU-1:0]                 fu_done_i,
    input  logic [NUM_FU*DATA_WIDTH-1:0]      fu_data_i,
    input  logic [NUM_FU-1:0]                 fu_exc_valid_i,
    input  logic [NUM_FU*32-1:0]              fu_exc_cause_i,
    input  logic                              flush_i,
    output logic [NUM_CDB-1:0]                cdb_valid_o,
    output logic [NUM_CDB*ROB_ADDR_WIDTH-1:0] cdb_rob_tag_o,
    output logic [NUM_CDB*DATA_WIDTH-1:0]     cdb_data_o,
    output logic [NUM_CDB-1:0]                cdb_exc_valid_o,
    output logic [NUM_CDB*32-1:0]             cdb_exc_cause_o,
    output logic                              protocol_err_o
);

    localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CW = $clog2(RES_DEPTH + 1);
    localparam int FW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [ROB_ADDR_WIDTH-1:0] buf_tag_r   [NUM_FU][RES_DEPTH];
    logic [DATA_WIDTH-1:0]     buf_data_r  [NUM_FU][RES_DEPTH];
    logic                      buf_exc_r   [NUM_FU][RES_DEPTH];
    logic [31:0]               buf_cause_r [NUM_FU][RES_DEPTH];
    logic [PW-1:0]             rd_ptr_r    [NUM_FU];
    logic [PW-1:0]             wr_ptr_r    [NUM_FU];
    logic [CW-1:0]             occ_r       [NUM_FU];
    logic [ROB_ADDR_WIDTH-1:0] tag_r       [NUM_FU];
    logic [NUM_FU-1:0]         pending_r;
    logic [NUM_FU-1:0]         kill_r;
    logic [FW-1:0]             rr_ptr_r;
    logic                      protocol_err_r;

    logic [NUM_FU-1:0]         eligible_s;
    logic [NUM_FU-1:0]         first_s;
    logic                      issue_ready_s;
    logic [NUM_FU-1:0]         grant_s;
    logic [NUM_CDB-1:0]        port_vld_s;
    logic [FW-1:0]             port_idx_s [NUM_CDB];
    logic [FW-1:0]             rr_next_s;
    logic                      proto_hit_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(RES_DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Per-unit dispatch eligibility and lowest-index selection.
    always_comb begin
        eligible_s = '0;
        first_s    = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            eligible_s[k] = (FU_CLASS_MAP[2*k +: 2] == issue_class_i) && (issue_class_i != 2'd3) &&
                            !fu_busy_i[k] && !pending_r[k] && !kill_r[k] &&
                            (occ_r[k] < CW'(RES_DEPTH));
        end
        for (int k = 0; k < NUM_FU; k++) begin
            first_s[k] = eligible_s[k] && ((eligible_s & ((NUM_FU'(1) << k) - NUM_FU'(1))) == '0);
        end
    end

    // Ready is held low during reset so the block looks empty until release.
    assign issue_ready_s  = rst_ni && !flush_i && (|eligible_s);
    assign issue_ready_o  = issue_ready_s;
    assign fu_start_o     = (issue_valid_i && issue_ready_s) ? first_s : '0;
    assign proto_hit_s    = |(fu_done_i & ~pending_r & ~kill_r);
    assign protocol_err_o = protocol_err_r;

    // Round-robin grant of up to NUM_CDB non-empty result buffers starting at rr_ptr.
    always_comb begin
        int          cnt_v;
        int          idx_i;
        logic [FW-1:0] idx_v;
        grant_s    = '0;
        port_vld_s = '0;
        rr_next_s  = rr_ptr_r;
        cnt_v      = 0;
        for (int j = 0; j < NUM_CDB; j++) begin
            port_idx_s[j] = '0;
        end
        for (int i = 0; i < NUM_FU; i++) begin
            idx_i = int'(rr_ptr_r) + i;
            if (idx_i >= NUM_FU) begin
                idx_i = idx_i - NUM_FU;
            end else begin
                idx_i = idx_i;
            end
            idx_v = FW'(idx_i);
            if ((occ_r[idx_v] != '0) && (cnt_v < NUM_CDB)) begin
                grant_s[idx_v] = 1'b1;
                for (int j = 0; j < NUM_CDB; j++) begin
                    if (j == cnt_v) begin
                        port_vld_s[j] = 1'b1;
                        port_idx_s[j] = idx_v;
                    end else begin
                        port_vld_s[j] = port_vld_s[j];
                    end
                end
                cnt_v     = cnt_v + 1;
                rr_next_s = FW'((idx_i + 1) % NUM_FU);
            end else begin
                cnt_v = cnt_v;
            end
        end
    end

    // Result bus driven straight from the granted buffer heads; idle ports read as zero.
    always_comb begin
        cdb_valid_o     = port_vld_s;
        cdb_rob_tag_o   = '0;
        cdb_data_o      = '0;
        cdb_exc_valid_o = '0;
        cdb_exc_cause_o = '0;
        for (int j = 0; j < NUM_CDB; j++) begin
            if (port_vld_s[j]) begin
                cdb_rob_tag_o[j*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH] = buf_tag_r[port_idx_s[j]][rd_ptr_r[port_idx_s[j]]];
                cdb_data_o[j*DATA_WIDTH +: DATA_WIDTH]            = buf_data_r[port_idx_s[j]][rd_ptr_r[port_idx_s[j]]];
                cdb_exc_valid_o[j]                                = buf_exc_r[port_idx_s[j]][rd_ptr_r[port_idx_s[j]]];
                cdb_exc_cause_o[j*32 +: 32]                       = buf_cause_r[port_idx_s[j]][rd_ptr_r[port_idx_s[j]]];
            end else begin
                cdb_exc_valid_o[j] = 1'b0;
            end
        end
    end

    // Outstanding-op tracking, per-unit result FIFOs, arbitration pointer and error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_r      <= '0;
            kill_r         <= '0;
            rr_ptr_r       <= '0;
            protocol_err_r <= 1'b0;
            for (int k = 0; k < NUM_FU; k++) begin
                rd_ptr_r[k] <= '0;
                wr_ptr_r[k] <= '0;
                occ_r[k]    <= '0;
                tag_r[k]    <= '0;
                for (int d = 0; d < RES_DEPTH; d++) begin
                    buf_tag_r[k][d]   <= '0;
                    buf_data_r[k][d]  <= '0;
                    buf_exc_r[k][d]   <= 1'b0;
                    buf_cause_r[k][d] <= '0;
                end
            end
        end else begin
            rr_ptr_r       <= rr_next_s;
            protocol_err_r <= protocol_err_r | proto_hit_s;
            // A done landing in a flush cycle retires the op instead of leaving it killed.
            pending_r <= fu_start_o | (pending_r & ~fu_done_i & ~{NUM_FU{flush_i}});
            kill_r    <= (kill_r & ~fu_done_i) | (pending_r & ~fu_done_i & {NUM_FU{flush_i}});
            for (int k = 0; k < NUM_FU; k++) begin
                if (fu_start_o[k]) begin
                    tag_r[k] <= issue_rob_tag_i;
                end else begin
                    tag_r[k] <= tag_r[k];
                end
                if (flush_i) begin
                    rd_ptr_r[k] <= '0;
                    wr_ptr_r[k] <= '0;
                    occ_r[k]    <= '0;
                end else begin
                    if (fu_done_i[k] && pending_r[k]) begin
                        buf_tag_r[k][wr_ptr_r[k]]   <= tag_r[k];
                        buf_data_r[k][wr_ptr_r[k]]  <= fu_data_i[k*DATA_WIDTH +: DATA_WIDTH];
                        buf_exc_r[k][wr_ptr_r[k]]   <= fu_exc_valid_i[k];
                        buf_cause_r[k][wr_ptr_r[k]] <= fu_exc_cause_i[k*32 +: 32];
                        wr_ptr_r[k]                 <= ptr_inc(wr_ptr_r[k]);
                    end else begin
                        wr_ptr_r[k] <= wr_ptr_r[k];
                    end
                    if (grant_s[k]) begin
                        rd_ptr_r[k] <= ptr_inc(rd_ptr_r[k]);
                    end else begin
                        rd_ptr_r[k] <= rd_ptr_r[k];
                    end
                    case ({fu_done_i[k] && pending_r[k], grant_s[k]})
                        2'b10:   occ_r[k] <= occ_r[k] + CW'(1);
                        2'b01:   occ_r[k] <= occ_r[k] - CW'(1);
                        default: occ_r[k] <= occ_r[k];
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_cluster_scheduler.sv
// Directed bench: stimulus pushes expected result-bus beats into a queue, a negedge monitor
// pops and compares each valid port; control outputs are checked inline against hand values.
module tb_exec_cluster_scheduler;

    logic         clk;
    logic         rst_n;
    logic         issue_valid;
    logic [1:0]   issue_class;
    logic [4:0]   issue_tag;
    logic         issue_ready;
    logic [3:0]   fu_start;
    logic [3:0]   fu_busy;
    logic [3:0]   fu_done;
    logic [127:0] fu_data;
    logic [3:0]   fu_exc_valid;
    logic [127:0] fu_exc_cause;
    logic         flush;
    logic [1:0]   cdb_valid;
    logic [9:0]   cdb_tag;
    logic [63:0]  cdb_data;
    logic [1:0]   cdb_exc_valid;
    logic [63:0]  cdb_exc_cause;
    logic         protocol_err;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] data;
        logic        exc;
        logic [31:0] cause;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    exec_cluster_scheduler dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .issue_valid_i   (issue_valid),
        .issue_class_i   (issue_class),
        .issue_rob_tag_i (issue_tag),
        .issue_ready_o   (issue_ready),
        .fu_start_o      (fu_start),
        .fu_busy_i       (fu_busy),
        .fu_done_i       (fu_done),
        .fu_data_i       (fu_data),
        .fu_exc_valid_i  (fu_exc_valid),
        .fu_exc_cause_i  (fu_exc_cause),
        .flush_i         (flush),
        .cdb_valid_o     (cdb_valid),
        .cdb_rob_tag_o   (cdb_tag),
        .cdb_data_o      (cdb_data),
        .cdb_exc_valid_o (cdb_exc_valid),
        .cdb_exc_cause_o (cdb_exc_cause),
        .protocol_err_o  (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [4:0] t, input logic [31:0] d, input logic e, input logic [31:0] c);
        exp_t x;
        x.tag = t; x.data = d; x.exc = e; x.cause = c;
        exp_q.push_back(x);
    endtask

    // Monitor: every valid bus port must match the next queued expectation, idle ports read zero.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int j = 0; j < 2; j++) begin
                if (cdb_valid[j]) begin
                    if (exp_q.size() == 0) begin
                        chk("cdb_unexpected_tag", {27'd0, cdb_tag[j*5 +: 5]}, 32'hFFFF_FFFF);
                    end else begin
                        exp_t x;
                        x = exp_q.pop_front();
                        chk("cdb_tag",   {27'd0, cdb_tag[j*5 +: 5]}, {27'd0, x.tag});
                        chk("cdb_data",  cdb_data[j*32 +: 32], x.data);
                        chk("cdb_exc",   {31'd0, cdb_exc_valid[j]}, {31'd0, x.exc});
                        chk("cdb_cause", cdb_exc_cause[j*32 +: 32], x.cause);
                    end
                end else begin
                    chk("cdb_idle_zero", {27'd0, cdb_tag[j*5 +: 5]} | cdb_data[j*32 +: 32] |
                        cdb_exc_cause[j*32 +: 32] | {31'd0, cdb_exc_valid[j]}, 32'd0);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; issue_valid = 1'b0; issue_class = 2'd0; issue_tag = 5'd0;
        fu_busy = 4'd0; fu_done = 4'd0; fu_data = '0; fu_exc_valid = 4'd0;
        fu_exc_cause = '0; flush = 1'b0;

        // reset state
        #1 issue_valid = 1'b1;
        #1;
        chk("rst_ready", {31'd0, issue_ready}, 32'd0);
        chk("rst_start", {28'd0, fu_start}, 32'd0);
        chk("rst_cdb_valid", {30'd0, cdb_valid}, 32'd0);
        chk("rst_perr", {31'd0, protocol_err}, 32'd0);
        issue_valid = 1'b0;
        step(); step();
        rst_n = 1'b1;

        // back-to-back ALU issues, then class blocking
        step(); issue_valid = 1'b1; issue_class = 2'd0; issue_tag = 5'd3; #1;
        chk("alu0_ready", {31'd0, issue_ready}, 32'd1);
        chk("alu0_start", {28'd0, fu_start}, 32'h1);
        step(); issue_tag = 5'd4; #1;
        chk("alu1_ready", {31'd0, issue_ready}, 32'd1);
        chk("alu1_start", {28'd0, fu_start}, 32'h2);
        step(); issue_tag = 5'd5; #1;
        chk("alu_full_ready", {31'd0, issue_ready}, 32'd0);
        chk("alu_full_start", {28'd0, fu_start}, 32'h0);
        issue_class = 2'd1; issue_tag = 5'd6; #1;
        chk("mul_start", {28'd0, fu_start}, 32'h4);
        step(); issue_class = 2'd3; #1;
        chk("cls3_ready", {31'd0, issue_ready}, 32'd0);
        issue_class = 2'd2; issue_tag = 5'd9; #1;
        chk("div_start", {28'd0, fu_start}, 32'h8);

        // all four done together, two-port bus drains in two cycles
        step(); issue_valid = 1'b0;
        fu_data = {32'h103, 32'h102, 32'h101, 32'h100};
        fu_exc_valid = 4'b0100; fu_exc_cause[64 +: 32] = 32'h55;
        fu_done = 4'b1111; #1;
        chk("no_bypass", {30'd0, cdb_valid}, 32'd0);
        push_exp(5'd3, 32'h100, 1'b0, 32'h0);
        push_exp(5'd4, 32'h101, 1'b0, 32'h0);
        push_exp(5'd6, 32'h102, 1'b1, 32'h55);
        push_exp(5'd9, 32'h103, 1'b0, 32'h0);
        step(); fu_done = 4'd0; fu_exc_valid = 4'd0; fu_exc_cause = '0; #1;
        chk("drain1_valid", {30'd0, cdb_valid}, 32'h3);
        step();
        chk("drain2_valid", {30'd0, cdb_valid}, 32'h3);
        step();
        chk("drain3_valid", {30'd0, cdb_valid}, 32'h0);

        // round-robin order after a lone grant on unit 1
        issue_valid = 1'b1; issue_class = 2'd0; issue_tag = 5'd10;
        step(); issue_tag = 5'd11;
        step(); issue_class = 2'd1; issue_tag = 5'd12;
        step(); issue_valid = 1'b0; fu_data[32 +: 32] = 32'hB1; fu_done = 4'b0010;
        push_exp(5'd11, 32'hB1, 1'b0, 32'h0);
        step(); fu_done = 4'd0; issue_valid = 1'b1; issue_class = 2'd0; issue_tag = 5'd13; #1;
        chk("reissue_unit1", {28'd0, fu_start}, 32'h2);
        step(); issue_valid = 1'b0;
        fu_data = {32'h0, 32'hA2, 32'hA1, 32'hA0}; fu_done = 4'b0111;
        push_exp(5'd12, 32'hA2, 1'b0, 32'h0);
        push_exp(5'd10, 32'hA0, 1'b0, 32'h0);
        push_exp(5'd13, 32'hA1, 1'b0, 32'h0);
        step(); fu_done = 4'd0;
        step(); step();

        // flush: pre-flush heads still appear, the rest is dropped, killed DIV recovers on done
        issue_valid = 1'b1; issue_class = 2'd0; issue_tag = 5'd20;
        step(); issue_tag = 5'd21;
        step(); issue_class = 2'd1; issue_tag = 5'd22;
        step(); issue_class = 2'd2; issue_tag = 5'd7; #1;
        chk("div7_start", {28'd0, fu_start}, 32'h8);
        step(); issue_valid = 1'b0;
        fu_data = {32'h0, 32'h222, 32'h221, 32'h220}; fu_done = 4'b0111;
        push_exp(5'd22, 32'h222, 1'b0, 32'h0);
        push_exp(5'd20, 32'h220, 1'b0, 32'h0);
        step(); fu_done = 4'd0; flush = 1'b1; issue_valid = 1'b1; issue_class = 2'd0; #1;
        chk("flush_ready", {31'd0, issue_ready}, 32'd0);
        chk("flush_start", {28'd0, fu_start}, 32'h0);
        chk("flush_cdb_valid", {30'd0, cdb_valid}, 32'h3);
        step(); flush = 1'b0; issue_valid = 1'b0; issue_class = 2'd2; #1;
        chk("killed_ready", {31'd0, issue_ready}, 32'd0);
        chk("post_flush_cdb", {30'd0, cdb_valid}, 32'h0);
        step(); fu_data[96 +: 32] = 32'hDEAD; fu_done = 4'b1000;
        step(); fu_done = 4'd0; #1;
        chk("div_ready_again", {31'd0, issue_ready}, 32'd1);
        chk("killed_done_perr", {31'd0, protocol_err}, 32'd0);
        chk("killed_done_cdb", {30'd0, cdb_valid}, 32'h0);

        // done with no outstanding op sets the sticky error
        step(); fu_data[32 +: 32] = 32'hBAD; fu_done = 4'b0010; #1;
        chk("perr_before", {31'd0, protocol_err}, 32'd0);
        step(); fu_done = 4'd0; #1;
        chk("perr_set", {31'd0, protocol_err}, 32'd1);
        step(); step();
        chk("perr_sticky", {31'd0, protocol_err}, 32'd1);

        // busy unit skipped; ready does not depend on issue_valid
        fu_busy = 4'b0001; issue_class = 2'd0; issue_valid = 1'b0; #1;
        chk("busy_ready", {31'd0, issue_ready}, 32'd1);
        chk("novalid_start", {28'd0, fu_start}, 32'h0);
        issue_valid = 1'b1; issue_tag = 5'd30; #1;
        chk("busy_skip_start", {28'd0, fu_start}, 32'h2);
        step(); #1;
        chk("busy_pending_ready", {31'd0, issue_ready}, 32'd0);
        fu_busy = 4'd0; issue_tag = 5'd31; #1;
        chk("unbusy_start", {28'd0, fu_start}, 32'h1);
        step(); issue_class = 2'd1; issue_tag = 5'd32;
        step(); issue_class = 2'd2; issue_tag = 5'd33;
        step(); issue_valid = 1'b0; fu_data = {32'h333, 32'h332, 32'h330, 32'h0}; fu_done = 4'b1110;

        // reset with three buffered results
        step(); fu_done = 4'd0; rst_n = 1'b0; issue_class = 2'd0; #1;
        chk("midrst_cdb_valid", {30'd0, cdb_valid}, 32'h0);
        chk("midrst_ready", {31'd0, issue_ready}, 32'd0);
        chk("midrst_perr", {31'd0, protocol_err}, 32'd0);
        step(); step();
        rst_n = 1'b1; #1;
        chk("post_rst_ready", {31'd0, issue_ready}, 32'd1);
        chk("post_rst_start", {28'd0, fu_start}, 32'h0);
        chk("post_rst_cdb", {30'd0, cdb_valid}, 32'h0);
        step(); step();
        chk("post_rst_perr", {31'd0, protocol_err}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exec_cluster_scheduler.md
EXEC_CLUSTER_SCHEDULER -- requirements
Module: exec_cluster_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, result data width.
REQ-002 SHALL have parameter ROB_ADDR_WIDTH, default 5, ROB tag width.
REQ-003 SHALL have parameter NUM_FU, default 4, number of external functional units; legal range 1..16.
REQ-004 SHALL have parameter FU_CLASS_MAP, default {2'd2,2'd1,2'd0,2'd0} (unit3..unit0), 2-bit class per unit: 0=ALU, 1=MUL, 2=DIV.
REQ-005 SHALL have parameter NUM_CDB, default 2, number of result-bus ports; legal range 1..NUM_FU.
REQ-006 SHALL have parameter RES_DEPTH, default 2, per-unit result buffer depth, power of two, >=1.
REQ-007 SHALL have ports: clk_i in 1, clock; rst_ni in 1, asynchronous active-low reset.
REQ-008 SHALL have ports: issue_valid_i in 1; issue_class_i in 2; issue_rob_tag_i in ROB_ADDR_WIDTH; issue_ready_o out 1.
REQ-009 SHALL have ports: fu_start_o out NUM_FU, one-hot start pulse; fu_busy_i in NUM_FU, unit busy.
REQ-010 SHALL have ports: fu_done_i in NUM_FU; fu_data_i in NUM_FU*DATA_WIDTH; fu_exc_valid_i in NUM_FU; fu_exc_cause_i in NUM_FU*32.
REQ-011 SHALL have ports: flush_i in 1, pipeline flush.
REQ-012 SHALL have ports: cdb_valid_o out NUM_CDB; cdb_rob_tag_o out NUM_CDB*ROB_ADDR_WIDTH; cdb_data_o out NUM_CDB*DATA_WIDTH; cdb_exc_valid_o out NUM_CDB; cdb_exc_cause_o out NUM_CDB*32.
REQ-013 SHALL have port protocol_err_o out 1, sticky protocol-violation flag.

Function
REQ-014 Unit k eligible iff class matches issue_class_i, !fu_busy_i[k], no outstanding op (pending[k]=0, kill[k]=0), buffer k occupancy < RES_DEPTH.
REQ-015 issue_ready_o SHALL be combinational: OR of eligibility over all units, forced 0 when flush_i=1; independent of issue_valid_i.
REQ-016 On issue_valid_i & issue_ready_o, fu_start_o SHALL pulse (same cycle) for the lowest-index eligible unit only; pending[k] set and issue_rob_tag_i captured into tag[k] at that edge.
REQ-017 Unknown class (3) SHALL never be eligible; issue_ready_o=0.
REQ-018 On fu_done_i[k] with pending[k]=1: push {tag[k], data, exc_valid, exc_cause} into buffer k at the edge; clear pending[k].
REQ-019 On fu_done_i[k] with kill[k]=1: discard result, clear kill[k].
REQ-020 On fu_done_i[k] with pending[k]=0 and kill[k]=0: discard, set protocol_err_o (cleared only by reset).
REQ-021 Minimum latency done->CDB SHALL be 1 cycle (no bypass); buffer is FIFO, wrap-around pointers, occupancy counter 0..RES_DEPTH.
REQ-022 CDB arbitration: each cycle grant up to NUM_CDB non-empty buffers, scanning round-robin from rr_ptr upward with wrap; grant j drives port j in scan order; unused ports valid=0, fields 0.
REQ-023 CDB outputs combinational from buffer heads; every granted buffer pops at the edge (no CDB backpressure).
REQ-024 rr_ptr SHALL advance to (last granted index+1) mod NUM_FU; unchanged if no grant.
REQ-025 Push and pop on same buffer same cycle SHALL both take effect, occupancy unchanged.
REQ-026 flush_i=1: all buffers emptied at edge; every pending unit moves to kill; cdb_valid_o still driven that cycle from pre-flush heads; fu_start_o=0; a done arriving in the flush cycle on a pending unit SHALL be discarded.
REQ-027 A unit with kill[k]=1 SHALL not be dispatchable until its done arrives.

Reset
REQ-028 rst_ni low (async): pending, kill, all buffers, rr_ptr=0, protocol_err_o=0; issue_ready_o, fu_start_o, cdb_valid_o and all cdb fields=0 while in reset.
REQ-029 Reset mid-operation SHALL drop all outstanding ops; first cycle after release behaves as empty block.

Verification
REQ-030 Two ALU issues tags 3,4 back-to-back, units idle -> fu_start_o=0001 then 0010; second cycle issue_ready_o=1.
REQ-031 Third ALU issue while units 0,1 pending -> issue_ready_o=0, no start; MUL issue same state -> fu_start_o=0100.
REQ-032 fu_done_i=1111 in one cycle, all pending with tags 1..4, NUM_CDB=2 -> next cycle CDB tags 1,2; following cycle 3,4; rr_ptr=0 afterward.
REQ-033 Unit 3 (DIV) pending tag 7, flush_i pulse, later done data 0xDEAD -> no CDB output, unit 3 eligible again next cycle, protocol_err_o=0.
REQ-034 fu_done_i[1] with no outstanding op -> result dropped, protocol_err_o=1 until reset.
REQ-035 Assert rst_ni low while buffers hold 3 results -> cdb_valid_o=0 immediately, all state cleared after release.
